fetch_unit: RTL

Instruction-fetch stage: the producer side of the IF/ID pipeline register. It owns the PC, runs a req/ready handshake with instruction memory, and presents instr_out/PC_out to IF/ID. It honours the stall from the hazard unit without losing a fetched word, and applies branch redirects from EX, raising flush_out so IF/ID kills the wrong-path instruction. An instr_out of 32'h00000000 marks a bubble; IF/ID converts it to NOP (32'h00000013).

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_skid_buf.sv | 40 ++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch controller states; encoding is fixed so downstream debug tools
    // can decode the state register directly.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    // All-zero word marks an empty slot; IF/ID turns it into NOP_INSTR.
    localparam logic [31:0] BUBBLE    = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_buf
//  Description : Single-entry instruction + PC holding register. Catches a
//                word that arrives while the consumer is stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic            valid
);

    // Clear wins over load so a redirect can never leave a stale entry valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= BUBBLE;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
        end
    end

endmodule : fetch_skid_buf
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : IF stage. Owns the PC, handshakes with instruction memory,
//                feeds IF/ID and applies EX branch redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] PC_out,
    output logic            flush_out
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] drop_addr;
    logic [31:0]     buf_instr;
    logic [XLEN-1:0] buf_pc;
    logic            buf_valid;
    logic            buf_load;
    logic            buf_clear;
    logic [XLEN-1:0] redirect_aligned;
    logic [XLEN-1:0] pc_next;

    assign redirect_aligned = redirect_pc & ~XLEN'(3);
    assign pc_next          = pc_reg + XLEN'(PC_STEP);

    // DROP keeps the abandoned request alive on its original address until
    // memory answers, so the bus never sees an address change mid-transfer.
    assign imem_req  = (state == ST_REQ) || (state == ST_DROP);
    assign imem_addr = (state == ST_DROP) ? drop_addr : pc_reg;
    assign flush_out = redirect_valid;

    // Park a response that arrives during a stall; release it when the stall lifts.
    assign buf_load  = !redirect_valid && (state == ST_REQ) && imem_ready && stall;
    assign buf_clear = redirect_valid || ((state == ST_HOLD) && !stall);

    fetch_skid_buf #(
        .XLEN (XLEN)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (buf_load),
        .clear    (buf_clear),
        .instr_in (imem_rdata),
        .pc_in    (pc_reg),
        .instr    (buf_instr),
        .pc       (buf_pc),
        .valid    (buf_valid)
    );

    // Fetch controller: redirect beats stall and beats a memory response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc_reg    <= RESET_PC;
            drop_addr <= '0;
            instr_out <= BUBBLE;
            PC_out    <= '0;
        end else if (redirect_valid) begin
            pc_reg    <= redirect_aligned;
            instr_out <= BUBBLE;
            PC_out    <= '0;
            if ((state == ST_REQ) && !imem_ready) begin
                state     <= ST_DROP;
                drop_addr <= pc_reg;
            end else if ((state == ST_DROP) && !imem_ready) begin
                state <= ST_DROP;
            end else begin
                state <= ST_REQ;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ready) begin
                        pc_reg <= pc_next;
                        if (stall) begin
                            state <= ST_HOLD;
                        end else begin
                            instr_out <= imem_rdata;
                            PC_out    <= pc_reg;
                        end
                    end else if (!stall) begin
                        instr_out <= BUBBLE;
                        PC_out    <= '0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        if (buf_valid) begin
                            instr_out <= buf_instr;
                            PC_out    <= buf_pc;
                        end else begin
                            instr_out <= BUBBLE;
                            PC_out    <= '0;
                        end
                        state <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_ready) begin
                        state <= ST_REQ;
                    end
                    if (!stall) begin
                        instr_out <= BUBBLE;
                        PC_out    <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : fetch_unit
`default_nettype wire
